sram_req_ctrl: RTL and testbench

//  Initiator-side controller for the single-port, registered-read SRAM macros
//  (ENABLE/WE/A/DI in, DO registered one cycle after a read).

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/sram_rsp_fifo.sv | 68 ++++++
 rtl/sram_req_ctrl.sv | 102 ++++++++++
 tb/tb_sram_req_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared widths, depth limits and sizing helpers for the SRAM request controller.
package sram_ctrl_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 16;
   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned RSP_DEPTH_DEF  = 3;
   // Two reads can be in flight while the head waits to be popped.
   localparam int unsigned RSP_DEPTH_MIN  = 3;
   localparam int unsigned CNT_WIDTH      = 32;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to index depth entries (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Response FIFO for SRAM read data; depth need not be a power of two.
module sram_rsp_fifo
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned DEPTH      = RSP_DEPTH_DEF,
   localparam int unsigned OCC_W     = occ_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [OCC_W-1:0]      occ_o
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Data storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (occ_q == OCC_W'(DEPTH));
   assign empty_o = (occ_q == '0);
   assign occ_o   = occ_q;

   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop_i |-> !empty_o);

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for a registered-read single-port SRAM with a credit-
// managed response FIFO so the read consumer may stall without losing data.
module sram_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned RSP_DEPTH  = RSP_DEPTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic [DATA_WIDTH-1:0] sram_di,
   input  logic [DATA_WIDTH-1:0] sram_do,
   output logic [CNT_WIDTH-1:0]  rd_cnt,
   output logic [CNT_WIDTH-1:0]  wr_cnt
);

   localparam int unsigned OCC_W = occ_width(RSP_DEPTH);
   localparam int unsigned CRD_W = OCC_W + 1;

   if (RSP_DEPTH < RSP_DEPTH_MIN) begin : g_bad_depth
      $error("sram_req_ctrl: RSP_DEPTH must be at least 3");
   end

   logic                 rd_pend_q, rd_pend_d;
   logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [OCC_W-1:0]     occ;
   logic [CRD_W-1:0]     in_flight;
   logic                 accept;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   // Credit: every accepted read owns a FIFO slot until it is popped.
   assign in_flight = CRD_W'(occ) + CRD_W'(rd_pend_q);
   assign req_ready = RST_N & (in_flight < CRD_W'(RSP_DEPTH));
   assign accept    = req_valid & req_ready;

   // Straight pass-through; the macro registers its own inputs.
   assign sram_en   = accept;
   assign sram_we   = req_we;
   assign sram_a    = req_addr;
   assign sram_di   = req_wdata;

   assign fifo_push = rd_pend_q;
   assign fifo_pop  = rsp_valid & rsp_ready;
   assign rsp_valid = ~fifo_empty;

   always_comb begin
      rd_pend_d = accept & ~req_we;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      if (accept & ~req_we) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
      if (accept &  req_we) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_pend_q <= 1'b0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;

   sram_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (CLK),
      .rst_n   (RST_N),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (sram_do),
      .rdata_o (rsp_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .occ_o   (occ)
   );

   a_no_push_full: assert property (@(posedge CLK) disable iff (!RST_N) fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Randomized bench for sram_req_ctrl against a request-level reference model
// plus a behavioural registered-read SRAM.
module tb_sram_req_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_rdata;
   logic        sram_en;
   logic        sram_we;
   logic [15:0] sram_a;
   logic [15:0] sram_di;
   logic [15:0] sram_do = '0;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   always #5 CLK = ~CLK;

   sram_req_ctrl dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .sram_en   (sram_en),
      .sram_we   (sram_we),
      .sram_a    (sram_a),
      .sram_di   (sram_di),
      .sram_do   (sram_do),
      .rd_cnt    (rd_cnt),
      .wr_cnt    (wr_cnt)
   );

   // External SRAM macro: 32 words, inputs registered, DO valid the cycle after a read.
   logic [15:0] sram_mem [32];
   always @(posedge CLK) begin
      if (sram_en) begin
         if (sram_we) sram_mem[sram_a[4:0]] <= sram_di;
         else         sram_do <= sram_mem[sram_a[4:0]];
      end
   end

   // Reference model: memory image, ordered expected responses with issue cycle.
   typedef struct {
      logic [15:0] data;
      int unsigned cyc;
   } rsp_t;

   logic [15:0] ref_mem [32];
   rsp_t        exp_q[$];
   int unsigned cyc = 0;
   logic [31:0] m_rd = '0;
   logic [31:0] m_wr = '0;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive at negedge, check combinational and registered outputs,
   // then advance the model by what the protocol says will happen at posedge.
   task automatic step(input logic rst_n, input logic v, input logic we,
                       input logic [15:0] a, input logic [15:0] d, input logic rr);
      logic exp_ready, exp_rv, exp_acc;
      @(negedge CLK);
      RST_N     = rst_n;
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      rsp_ready = rr;
      #1;
      if (!rst_n) begin
         exp_q.delete();
         m_rd = '0;
         m_wr = '0;
         check("rst_req_ready", 32'(req_ready), 32'd0);
         check("rst_sram_en",   32'(sram_en),   32'd0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_rd_cnt",    rd_cnt,         32'd0);
         check("rst_wr_cnt",    wr_cnt,         32'd0);
         cyc++;
         return;
      end
      exp_ready = (exp_q.size() < 3);
      exp_rv    = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
      exp_acc   = v & exp_ready;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].data));
      check("sram_en", 32'(sram_en), 32'(exp_acc));
      if (exp_acc) begin
         check("sram_we", 32'(sram_we), 32'(we));
         check("sram_a",  32'(sram_a),  32'(a));
         if (we) check("sram_di", 32'(sram_di), 32'(d));
      end
      check("rd_cnt", rd_cnt, m_rd);
      check("wr_cnt", wr_cnt, m_wr);
      if (exp_rv && rr) void'(exp_q.pop_front());
      if (exp_acc) begin
         if (we) begin
            ref_mem[a[4:0]] = d;
            m_wr = m_wr + 32'd1;
         end else begin
            exp_q.push_back('{data: ref_mem[a[4:0]], cyc: cyc});
            m_rd = m_rd + 32'd1;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, rr);
   endtask

   int unsigned n_acc;

   initial begin
      for (int i = 0; i < 32; i++) begin
         ref_mem[i]  = 16'($urandom);
         sram_mem[i] = ref_mem[i];
      end

      // Reset held with a live request on the bus.
      step(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 16'h0004, 16'hBEEF, 1'b1);
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Write then read the same address in consecutive cycles.
      step(1'b1, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b1);
      step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("wr_rd_early", 32'(rsp_valid), 32'd0);
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      check("wr_rd_valid", 32'(rsp_valid), 32'd1);
      check("wr_rd_data",  32'(rsp_rdata), 32'h1234);
      idle(3, 1'b1);

      // Full-rate reads with a consumer that never stalls.
      n_acc = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'($urandom_range(0, 31)), 16'h0, 1'b1);
         if (req_ready) n_acc++;
      end
      check("b2b_accepts", n_acc, 32'd100);
      idle(4, 1'b1);

      // Stalled consumer: only three reads fit.
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'($urandom_range(0, 31)), 16'h0, 1'b0);
         if (sram_en) n_acc++;
      end
      check("stall_accepts", n_acc, 32'd3);
      step(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0, 1'b0);
      check("stall_ready", 32'(req_ready), 32'd0);
      idle(5, 1'b1);

      // Reset while one read is in flight and two are buffered.
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 1'b0, 16'($urandom_range(0, 31)), 16'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("rst_mid_no_stale", 32'(rsp_valid), 32'd0);
      idle(2, 1'b1);

      // Write counter wrap from all-ones.
      force dut.wr_cnt_q = 32'hFFFF_FFFF;
      m_wr = 32'hFFFF_FFFF;
      idle(1, 1'b1);
      release dut.wr_cnt_q;
      step(1'b1, 1'b1, 1'b1, 16'h0005, 16'hA5A5, 1'b1);
      idle(1, 1'b1);
      check("wr_cnt_wrap", wr_cnt, 32'd0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 499) != 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              16'($urandom_range(0, 31)),
              16'($urandom),
              ($urandom_range(0, 9) < 6));
      end
      idle(8, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
